// File: rtl/hex_2_ascii_streamer.sv
// Streams a captured binary word as ASCII hex characters, MS nibble first,
// optionally followed by CR LF, over a valid/ready byte handshake.
module hex_2_ascii_streamer #(
    parameter int NIBBLES     = 4,
    parameter bit UPPERCASE   = 1'b1,
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*NIBBLES-1:0] value_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic [7:0]           ascii_o,
    output logic                 ascii_valid_o,
    input  logic                 ascii_ready_i,
    output logic                 done_o
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NIBBLES - 1);
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        DIGIT,
        CR,
        LF
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    ascii_d;
    logic          valid_d, busy_d, done_d;
    logic          xfer;
    logic          finish;
    logic [W-1:0]  shifted;

    function automatic logic [7:0] encode(input logic [3:0] n);
        logic [7:0] n8;
        n8 = {4'h0, n};
        if (n < 4'd10) return 8'h30 + n8;
        return (UPPERCASE ? 8'h41 : 8'h61) + n8 - 8'd10;
    endfunction

    assign xfer    = ascii_valid_o && ascii_ready_i;
    assign shifted = shreg_q << 4;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ascii_d = ascii_o;
        valid_d = ascii_valid_o;
        busy_d  = busy_o;
        done_d  = 1'b0;
        finish  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shreg_d = value_i;
                    cnt_d   = '0;
                    ascii_d = encode(value_i[W-1 -: 4]);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = DIGIT;
                end
            end
            DIGIT: begin
                if (xfer) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q != LAST_DIGIT) begin
                        // Next digit is loaded on the same edge: no bubble.
                        ascii_d = encode(shifted[W-1 -: 4]);
                    end else if (APPEND_CRLF) begin
                        ascii_d = CHAR_CR;
                        state_d = CR;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            CR: begin
                if (xfer) begin
                    ascii_d = CHAR_LF;
                    state_d = LF;
                end
            end
            LF: begin
                if (xfer) finish = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            ascii_o       <= 8'h00;
            ascii_valid_o <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            ascii_o       <= ascii_d;
            ascii_valid_o <= valid_d;
            busy_o        <= busy_d;
            done_o        <= done_d;
        end
    end

endmodule

// File: tb/tb_hex_2_ascii_streamer.sv
// Randomized self-checking bench for hex_2_ascii_streamer; dut_a uses the
// defaults, dut_b is lowercase without CR LF.
module tb_hex_2_ascii_streamer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] value_a = '0, value_b = '0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        ready_a = 1'b0, ready_b = 1'b0;
    logic        busy_a, busy_b, valid_a, valid_b, done_a, done_b;
    logic [7:0]  ascii_a, ascii_b;

    hex_2_ascii_streamer #(.NIBBLES(4), .UPPERCASE(1'b1), .APPEND_CRLF(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .value_i(value_a), .start_i(start_a),
        .busy_o(busy_a), .ascii_o(ascii_a), .ascii_valid_o(valid_a),
        .ascii_ready_i(ready_a), .done_o(done_a)
    );

    hex_2_ascii_streamer #(.NIBBLES(4), .UPPERCASE(1'b0), .APPEND_CRLF(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .value_i(value_b), .start_i(start_b),
        .busy_o(busy_b), .ascii_o(ascii_b), .ascii_valid_o(valid_b),
        .ascii_ready_i(ready_b), .done_o(done_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit         sel_b = 1'b0;
    logic       s_valid, s_busy, s_done;
    logic [7:0] s_ascii;

    always_comb begin
        s_valid = sel_b ? valid_b : valid_a;
        s_busy  = sel_b ? busy_b  : busy_a;
        s_done  = sel_b ? done_b  : done_a;
        s_ascii = sel_b ? ascii_b : ascii_a;
    end

    byte unsigned got[$];
    byte unsigned exp_q[$];
    int done_at, first_valid, hold_err, busy_err;

    // Reference model: look up each nibble's character in a hex digit table.
    task automatic build_expected(input logic [15:0] v, input bit uc, input bit crlf);
        string dig_uc = "0123456789ABCDEF";
        string dig_lc = "0123456789abcdef";
        exp_q.delete();
        for (int i = 3; i >= 0; i--) begin
            int nib = int'(v >> (4 * i)) & 15;
            exp_q.push_back(uc ? dig_uc[nib] : dig_lc[nib]);
        end
        if (crlf) begin
            exp_q.push_back(8'd13);
            exp_q.push_back(8'd10);
        end
    endtask

    task automatic drive(input logic st, input logic [15:0] v, input logic rdy);
        if (sel_b) begin
            start_b = st; value_b = v; ready_b = rdy;
        end else begin
            start_a = st; value_a = v; ready_a = rdy;
        end
    endtask

    // Runs one message on the selected DUT, collecting transferred bytes.
    // Inputs change at negedge; outputs are sampled at negedge.
    task automatic run_msg(input bit issue_start, input logic [15:0] v, input int ready_pct,
                           input int busy_start_cyc, input logic [15:0] busy_val,
                           input bit chain, input logic [15:0] chain_val);
        bit         stall = 1'b0;
        bit         rdy;
        bit         st;
        logic [7:0] prev_ascii = 8'h00;
        got.delete();
        done_at = -1; first_valid = -1; hold_err = 0; busy_err = 0;
        if (issue_start) begin
            @(negedge clk);
            drive(1'b1, v, 1'b0);
        end
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (stall && (s_valid !== 1'b1 || s_ascii !== prev_ascii)) hold_err++;
            if (s_done === 1'b1) begin
                done_at = cyc;
                if (s_valid !== 1'b0 || s_busy !== 1'b0) busy_err++;
                if (chain) drive(1'b1, chain_val, 1'b1);
                else       drive(1'b0, 16'h0000, 1'b0);
                break;
            end
            if (s_busy !== 1'b1) busy_err++;
            if (s_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            rdy = ($urandom_range(0, 99) < ready_pct);
            if (s_valid === 1'b1 && rdy) got.push_back(s_ascii);
            stall      = (s_valid === 1'b1) && !rdy;
            prev_ascii = s_ascii;
            st         = (cyc == busy_start_cyc);
            drive(st, st ? busy_val : 16'($urandom), rdy);
        end
        if (done_at < 0) drive(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_reset;
        #3;
        n_tests++;
        if ({busy_a, valid_a, done_a, ascii_a} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_a: got busy=%b valid=%b done=%b ascii=%h, want all 0",
                     busy_a, valid_a, done_a, ascii_a);
        end
        n_tests++;
        if ({busy_b, valid_b, done_b, ascii_b} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_b: got busy=%b valid=%b done=%b ascii=%h, want all 0",
                     busy_b, valid_b, done_b, ascii_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_default_stream;
        sel_b = 1'b0;
        build_expected(16'h1A2F, 1'b1, 1'b1);
        run_msg(1'b1, 16'h1A2F, 100, 0, 16'h0, 1'b0, 16'h0);
        n_tests++;
        if (got.size() != 6) begin
            n_fail++; $display("FAIL default_len: got %0d bytes, want 6", got.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL default_byte%0d: got %h, want %h", i,
                                   (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
        n_tests++;
        if (done_at != 7 || first_valid != 1) begin
            n_fail++; $display("FAIL default_timing: done at %0d first valid %0d, want 7 and 1",
                               done_at, first_valid);
        end
    endtask

    task automatic test_lowercase_no_crlf;
        sel_b = 1'b1;
        build_expected(16'hBEEF, 1'b0, 1'b0);
        run_msg(1'b1, 16'hBEEF, 100, 0, 16'h0, 1'b0, 16'h0);
        n_tests++;
        if (got.size() != 4) begin
            n_fail++; $display("FAIL lc_len: got %0d bytes, want 4", got.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL lc_byte%0d: got %h, want %h", i,
                                   (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
        n_tests++;
        if (done_at != 5) begin
            n_fail++; $display("FAIL lc_done: done at %0d, want 5", done_at);
        end
        sel_b = 1'b0;
    endtask

    task automatic test_backpressure;
        sel_b = 1'b0;
        build_expected(16'h0009, 1'b1, 1'b1);
        run_msg(1'b1, 16'h0009, 50, 0, 16'h0, 1'b0, 16'h0);
        n_tests++;
        if (got.size() != exp_q.size() || done_at < 7) begin
            n_fail++; $display("FAIL bp_len: got %0d bytes done at %0d, want %0d bytes done >= 7",
                               got.size(), done_at, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL bp_byte%0d: got %h, want %h", i,
                                   (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
        n_tests++;
        if (hold_err != 0 || busy_err != 0) begin
            n_fail++; $display("FAIL bp_hold: got %0d hold and %0d busy errors, want 0 and 0",
                               hold_err, busy_err);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 12; k++) begin
            logic [15:0] v;
            int pct;
            sel_b = bit'($urandom_range(0, 1));
            v     = 16'($urandom);
            pct   = $urandom_range(30, 100);
            build_expected(v, !sel_b, !sel_b);
            run_msg(1'b1, v, pct, 0, 16'h0, 1'b0, 16'h0);
            n_tests++;
            if (got.size() != exp_q.size() || done_at < exp_q.size() + 1 ||
                hold_err != 0 || busy_err != 0) begin
                n_fail++;
                $display("FAIL rand%0d_shape: v=%h len %0d done %0d hold %0d busy %0d, want len %0d",
                         k, v, got.size(), done_at, hold_err, busy_err, exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (i >= got.size() || got[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand%0d_byte%0d: v=%h got %h, want %h", k, i, v,
                                       (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
                end
            end
        end
        sel_b = 1'b0;
    endtask

    task automatic test_back_to_back;
        sel_b = 1'b0;
        build_expected(16'h00FF, 1'b1, 1'b1);
        run_msg(1'b1, 16'h00FF, 100, 2, 16'h1234, 1'b1, 16'h1234);
        n_tests++;
        if (got.size() != exp_q.size() || done_at != 7) begin
            n_fail++; $display("FAIL busy_start_len: got %0d bytes done %0d, want 6 done 7",
                               got.size(), done_at);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL busy_start_byte%0d: got %h, want %h", i,
                                   (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
        build_expected(16'h1234, 1'b1, 1'b1);
        run_msg(1'b0, 16'h1234, 100, 0, 16'h0, 1'b0, 16'h0);
        n_tests++;
        if (first_valid != 1 || done_at != 7) begin
            n_fail++; $display("FAIL b2b_gap: first valid %0d done %0d, want 1 and 7",
                               first_valid, done_at);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_byte%0d: got %h, want %h", i,
                                   (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int done_seen = 0;
        sel_b = 1'b0;
        @(negedge clk);
        drive(1'b1, 16'hCAFE, 1'b1);
        @(negedge clk);
        drive(1'b0, 16'hCAFE, 1'b1);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (valid_a !== 1'b1 || ascii_a !== 8'h46) begin
            n_fail++; $display("FAIL mid_third_char: got valid=%b ascii=%h, want 1 46",
                               valid_a, ascii_a);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy_a, valid_a, done_a, ascii_a} !== 11'h000) begin
            n_fail++; $display("FAIL mid_async_reset: got busy=%b valid=%b done=%b ascii=%h, want all 0",
                               busy_a, valid_a, done_a, ascii_a);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) done_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_a === 1'b1 || valid_a === 1'b1) done_seen++;
        end
        n_tests++;
        if (done_seen != 0) begin
            n_fail++; $display("FAIL mid_no_done: got %0d done/valid cycles, want 0", done_seen);
        end
        drive(1'b0, 16'h0000, 1'b0);
        build_expected(16'hCAFE, 1'b1, 1'b1);
        run_msg(1'b1, 16'hCAFE, 100, 0, 16'h0, 1'b0, 16'h0);
        n_tests++;
        if (got.size() != exp_q.size() || done_at != 7) begin
            n_fail++; $display("FAIL mid_restart_len: got %0d bytes done %0d, want 6 done 7",
                               got.size(), done_at);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL mid_restart_byte%0d: got %h, want %h", i,
                                   (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_stream();
        test_lowercase_no_crlf();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
